// File: rtl/pwm_sample_sched.sv
// Per-sample scheduler for the PWM DAC: polls NV voices in order, sums their samples,
// applies the gain shift and saturation, and presents the result as offset binary.

module pwm_sample_lane #(
  parameter int SW = 16,
  parameter int AW = 19
) (
  input  logic          sel,
  input  logic          en,
  input  logic          valid,
  input  logic [SW-1:0] data,
  output logic          ready,
  output logic          miss,
  output logic [AW-1:0] term
);
  assign ready = sel & en;
  assign miss  = sel & en & ~valid;
  assign term  = (ready & valid) ? {{(AW-SW){data[SW-1]}}, data} : '0;
endmodule

module pwm_sample_sched #(
  parameter int NV    = 4,
  parameter int SW    = 16,
  parameter int NBITS = 12,
  parameter int SHIFT = 6
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             next_val,
  input  logic [NV*SW-1:0] voice_data,
  input  logic [NV-1:0]    voice_valid,
  output logic [NV-1:0]    voice_ready,
  input  logic [NV-1:0]    voice_en,
  input  logic             mute,
  output logic [NBITS-1:0] data_out,
  output logic             busy,
  output logic             underrun,
  output logic             overrun,
  input  logic             clr_status
);
  localparam int IW = (NV > 1) ? $clog2(NV) : 1;
  localparam int AW = SW + $clog2(NV) + 1;
  localparam logic signed [AW-1:0] HI = AW'((1 << (NBITS-1)) - 1);
  localparam logic signed [AW-1:0] LO = ~HI;
  localparam logic [NBITS-1:0] MID = NBITS'(1 << (NBITS-1));

  typedef enum logic [1:0] {IDLE, FETCH, SCALE, LOAD} state_t;
  state_t state, state_nxt;

  logic [IW-1:0]          idx;
  logic signed [AW-1:0]   acc;
  logic signed [AW-1:0]   shv;
  logic [NBITS-1:0]       sat_q;
  logic [NV-1:0][AW-1:0]  term;
  logic [NV-1:0]          miss;
  logic [AW-1:0]          term_sum;
  logic                   last;

  // Only the lane selected by idx can contribute, so OR-ing the terms is a mux.
  for (genvar gi = 0; gi < NV; gi++) begin : g_lane
    pwm_sample_lane #(.SW(SW), .AW(AW)) u_lane (
      .sel   (state == FETCH && idx == IW'(gi)),
      .en    (voice_en[gi]),
      .valid (voice_valid[gi]),
      .data  (voice_data[gi*SW +: SW]),
      .ready (voice_ready[gi]),
      .miss  (miss[gi]),
      .term  (term[gi])
    );
  end

  always_comb begin
    term_sum = '0;
    for (int i = 0; i < NV; i++) term_sum = term_sum | term[i];
  end

  assign last = (idx == IW'(NV-1));
  assign busy = (state != IDLE);
  assign shv  = acc >>> SHIFT;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (next_val) state_nxt = FETCH;
      FETCH:   if (last) state_nxt = SCALE;
      SCALE:   state_nxt = LOAD;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      idx      <= '0;
      acc      <= '0;
      sat_q    <= '0;
      data_out <= MID;
      underrun <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (next_val) begin
          idx <= '0;
          acc <= '0;
        end
        FETCH: begin
          acc <= acc + $signed(term_sum);
          if (!last) idx <= idx + 1'b1;
        end
        SCALE: sat_q <= (shv > HI) ? HI[NBITS-1:0] :
                        (shv < LO) ? LO[NBITS-1:0] : shv[NBITS-1:0];
        LOAD:  data_out <= mute ? MID : {~sat_q[NBITS-1], sat_q[NBITS-2:0]};
        default: ;
      endcase
      // A set in the same cycle as a clear takes precedence.
      underrun <= (underrun & ~clr_status) | (|miss);
      overrun  <= (overrun  & ~clr_status) | (next_val & busy);
    end
  end
endmodule
